// File: rtl/lc3b_types.sv
// lc3b_types: shared LC-3b word type and fetch-stage state encoding.
package lc3b_types;
    typedef logic [15:0] lc3b_word;
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} lc3b_fetch_state;
endpackage

// File: rtl/lc3b_fetch_unit_if.sv
// lc3b_fetch_unit_if: instruction-memory read/response handshake.
interface lc3b_fetch_unit_if;
    import lc3b_types::*;
    logic     read;
    lc3b_word address;
    logic     resp;
    lc3b_word rdata;
    modport master (output read, address, input resp, rdata);
    modport slave (input read, address, output resp, rdata);
endinterface

// File: rtl/lc3b_fetch_unit.sv
// lc3b_fetch_unit: IF stage with a one-entry skid buffer and redirect draining of in-flight reads.
module lc3b_fetch_unit
    import lc3b_types::*;
#(
    parameter lc3b_word RESET_PC = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect,
    input  lc3b_word           redirect_pc,
    lc3b_fetch_unit_if.master  imem,
    output logic               instr_valid,
    output lc3b_word           instr_out,
    output lc3b_word           pc_plus2_out
);
    lc3b_fetch_state state;
    lc3b_word        pc, drain_addr, skid_instr, skid_pc2, pc_next;
    logic            skid_valid, consume, slot_free;

    assign consume      = instr_valid && !stall;
    assign slot_free    = !instr_valid || !stall;
    assign pc_next      = pc + 16'd2;
    assign imem.read    = rst_n && state != HOLD;
    // a drained read keeps its original address even after pc moves to the new target
    assign imem.address = state == DRAIN ? drain_addr : pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc           <= RESET_PC;
            drain_addr   <= RESET_PC;
            instr_valid  <= 1'b0;
            instr_out    <= '0;
            pc_plus2_out <= '0;
            skid_valid   <= 1'b0;
            skid_instr   <= '0;
            skid_pc2     <= '0;
        end else if (redirect) begin
            instr_valid <= 1'b0;
            skid_valid  <= 1'b0;
            pc          <= redirect_pc;
            if (state == FETCH && !imem.resp) begin
                state      <= DRAIN;
                drain_addr <= pc;
            end else if (state != DRAIN) begin
                state <= FETCH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (imem.resp) begin
                        pc <= pc_next;
                        if (slot_free) begin
                            instr_out    <= imem.rdata;
                            pc_plus2_out <= pc_next;
                            instr_valid  <= 1'b1;
                        end else begin
                            skid_instr <= imem.rdata;
                            skid_pc2   <= pc_next;
                            skid_valid <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (consume) begin
                        instr_valid <= 1'b0;
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        instr_out    <= skid_instr;
                        pc_plus2_out <= skid_pc2;
                        instr_valid  <= skid_valid;
                        skid_valid   <= 1'b0;
                        state        <= FETCH;
                    end
                end
                DRAIN: begin
                    if (imem.resp) state <= FETCH;
                    if (consume) instr_valid <= 1'b0;
                end
                default: state <= FETCH;
            endcase
        end
    end
endmodule
